// File: rtl/clk_div_cfg_pkg.sv
// Shared types and widths for the divider retune scheduler.
package clk_div_cfg_pkg;
  localparam int DIV_W = 12;
  localparam int TMO_W = 16;
  localparam int SET_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GATE    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;
endpackage

// File: rtl/clk_rr_arb.sv
// Combinational round-robin picker; search begins one past the last winner.
module clk_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  int   w_j;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_j]) begin
        w_found       = 1'b1;
        o_idx         = IW'(w_j);
        o_grant[w_j]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/clk_div_cfg_sched.sv
// Arbitrates divide-value requests and sequences a glitch-free divider retune.
//   state   | meaning
//   IDLE    | no owner, arbitrating requests
//   GATE    | divided clock gated, waiting for divider edge or timeout
//   LOAD    | new divide value written to AClkDiv
//   SETTLE  | divider settling, clock still gated
//   RELEASE | ungate, ADone/AErr pulse to owner
module clk_div_cfg_sched
  import clk_div_cfg_pkg::*;
#(
  parameter int               CReqCnt  = 4,
  parameter logic [DIV_W-1:0] CDivInit = 12'h170,
  parameter logic [SET_W-1:0] CSettle  = 8'd16,
  parameter logic [TMO_W-1:0] CTimeout = 16'd4096
) (
  input  logic                       AClkH,
  input  logic                       AResetHN,
  input  logic                       AClkHEn,
  input  logic [CReqCnt-1:0]         AReq,
  input  logic [DIV_W*CReqCnt-1:0]   AReqDiv,
  output logic [CReqCnt-1:0]         AGrant,
  output logic [CReqCnt-1:0]         ADone,
  output logic                       AErr,
  output logic [DIV_W-1:0]           AClkDiv,
  output logic                       AGateN,
  input  logic                       AEdgeSync,
  output logic                       ABusy
);
  localparam int IW = $clog2(CReqCnt);

  state_e             r_state, w_state_nxt;
  logic [IW-1:0]      r_ptr, w_win_idx;
  logic [CReqCnt-1:0] r_grant, w_win_oh, w_done;
  logic [DIV_W-1:0]   r_new_div, r_clk_div, w_req_div;
  logic [TMO_W-1:0]   r_tmo;
  logic [SET_W-1:0]   r_set;
  logic               r_forced, r_gate_n, w_err, w_tmo_tc, w_set_last;

  clk_rr_arb #(.N(CReqCnt), .IW(IW)) u_arb (
    .i_req   (AReq),
    .i_ptr   (r_ptr),
    .o_grant (w_win_oh),
    .o_idx   (w_win_idx)
  );

  always_comb begin
    w_req_div = '0;
    for (int i = 0; i < CReqCnt; i++) begin
      if (w_win_idx == IW'(i)) w_req_div = AReqDiv[i*DIV_W +: DIV_W];
    end
  end

  assign w_tmo_tc   = (r_tmo == CTimeout - TMO_W'(1));
  assign w_set_last = (r_set <= SET_W'(1));

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN)    r_state <= ST_IDLE;
    else if (AClkHEn) r_state <= w_state_nxt;
  end

  // Pulses are qualified by the enable so a frozen RELEASE emits nothing.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = '0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE:    if (|AReq) w_state_nxt = (w_req_div == r_clk_div) ? ST_RELEASE : ST_GATE;
      ST_GATE:    if (AEdgeSync || w_tmo_tc) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (w_set_last) w_state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_done      = r_grant & {CReqCnt{AClkHEn}};
        w_err       = r_forced & AClkHEn;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_new_div <= '0;
      r_clk_div <= CDivInit;
      r_tmo     <= '0;
      r_set     <= '0;
      r_forced  <= 1'b0;
      r_gate_n  <= 1'b1;
    end else if (AClkHEn) begin
      case (r_state)
        ST_IDLE: if (|AReq) begin
          r_grant   <= w_win_oh;
          r_new_div <= w_req_div;
          r_ptr     <= w_win_idx;
          r_tmo     <= '0;
          if (w_req_div != r_clk_div) r_gate_n <= 1'b0;
        end
        ST_GATE: begin
          if (!AEdgeSync && w_tmo_tc) r_forced <= 1'b1;
          else if (!AEdgeSync)        r_tmo    <= r_tmo + TMO_W'(1);
        end
        ST_LOAD: begin
          r_clk_div <= r_new_div;
          r_set     <= CSettle;
        end
        ST_SETTLE: begin
          if (w_set_last) r_gate_n <= 1'b1;
          else            r_set    <= r_set - SET_W'(1);
        end
        ST_RELEASE: begin
          r_grant  <= '0;
          r_forced <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign AGrant  = r_grant;
  assign ADone   = w_done;
  assign AErr    = w_err;
  assign AClkDiv = r_clk_div;
  assign AGateN  = r_gate_n;
  assign ABusy   = (r_state != ST_IDLE);
endmodule

// File: tb/tb_clk_div_cfg_sched.sv
// Bench for clk_div_cfg_sched: timeline-based reference model plus directed literal checks.
module tb_clk_div_cfg_sched;
  localparam int          N        = 4;
  localparam int          CSETTLE  = 16;
  localparam int          CTIMEOUT = 4096;
  localparam logic [11:0] DIV_INIT = 12'h170;

  logic            AClkH = 1'b0, AResetHN = 1'b0, AClkHEn = 1'b1, AEdgeSync = 1'b0;
  logic [N-1:0]    AReq = '0;
  logic [12*N-1:0] AReqDiv = '0;
  logic [N-1:0]    AGrant, ADone;
  logic            AErr, AGateN, ABusy;
  logic [11:0]     AClkDiv;

  int checks = 0, errors = 0;
  int done_log[$];
  logic [N-1:0] last_done = '0;

  clk_div_cfg_sched #(
    .CReqCnt(N), .CDivInit(DIV_INIT), .CSettle(8'(CSETTLE)), .CTimeout(16'(CTIMEOUT))
  ) dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .AReq(AReq), .AReqDiv(AReqDiv),
    .AGrant(AGrant), .ADone(ADone), .AErr(AErr), .AClkDiv(AClkDiv), .AGateN(AGateN),
    .AEdgeSync(AEdgeSync), .ABusy(ABusy)
  );

  always #5 AClkH = ~AClkH;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  // Model: n counts enabled edges; each sequence is a set of timestamps in that count.
  int          n, m_s, m_rel_n, m_div_n, m_owner, m_ptr;
  bit          m_busy, m_gated, m_gating, m_forced;
  logic [11:0] m_div, m_new;

  initial forever begin
    @(posedge AClkH or negedge AResetHN);
    if (!AResetHN) begin
      n = 0; m_s = 0; m_rel_n = 0; m_div_n = 0; m_owner = 0; m_ptr = 0;
      m_busy = 0; m_gated = 0; m_gating = 0; m_forced = 0;
      m_div = DIV_INIT; m_new = '0;
    end else if (AClkHEn) begin
      if (!m_busy) begin
        if (AReq != '0) begin
          m_owner = rr_pick(AReq, m_ptr);
          m_ptr   = m_owner;
          m_new   = AReqDiv[m_owner*12 +: 12];
          m_busy  = 1; m_forced = 0; m_s = n + 1;
          if (m_new == m_div) begin m_gated = 0; m_gating = 0; m_rel_n = n + 1; end
          else begin m_gated = 1; m_gating = 1; end
        end
      end else if (m_gating) begin
        if (AEdgeSync || (n - m_s) == CTIMEOUT - 1) begin
          m_gating = 0; m_forced = !AEdgeSync;
          m_div_n = n + 2; m_rel_n = n + 2 + CSETTLE;
        end
      end else if (n == m_rel_n) begin
        m_busy = 0; m_div = m_new;
      end
      n++;
    end
  end

  initial forever begin
    logic [N-1:0] e_grant, e_done;
    logic         e_gate_n, e_err;
    logic [11:0]  e_div;
    @(negedge AClkH);
    e_grant  = m_busy ? (N'(1) << m_owner) : '0;
    e_gate_n = !(m_busy && m_gated && (m_gating || n < m_rel_n));
    e_div    = (m_busy && m_gated && !m_gating && n >= m_div_n) ? m_new : m_div;
    e_done   = (m_busy && !m_gating && n == m_rel_n && AClkHEn) ? e_grant : '0;
    e_err    = (e_done != '0) && m_forced;
    chk("grant", 32'(AGrant), 32'(e_grant));
    chk("done", 32'(ADone), 32'(e_done));
    chk("err", 32'(AErr), 32'(e_err));
    chk("clkdiv", 32'(AClkDiv), 32'(e_div));
    chk("gate_n", 32'(AGateN), 32'(e_gate_n));
    chk("busy", 32'(ABusy), 32'(m_busy));
    last_done = ADone;
    for (int i = 0; i < N; i++) if (ADone[i]) done_log.push_back(i);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    AResetHN = 1'b0; AReq = '0; AEdgeSync = 1'b0; AClkHEn = 1'b1;
    repeat (3) @(posedge AClkH);
    #2 AResetHN = 1'b1;
  endtask

  // Interval 0 is the IDLE cycle in which the request is first visible.
  task automatic run_seq(input int edge_at, input int off_at, input int off_len, input int max_c,
                         input logic [11:0] tgt, output int done_c, output int div_c,
                         output int low_cnt, output logic err_at);
    done_c = -1; div_c = -1; low_cnt = 0; err_at = 1'b0;
    for (int c = 0; c < max_c && (done_c < 0 || c < done_c + 3); c++) begin
      AEdgeSync = (c == edge_at);
      AClkHEn   = !(c >= off_at && c < off_at + off_len);
      if (done_c >= 0) AReq = '0;
      @(negedge AClkH);
      if (!AGateN) low_cnt++;
      if (div_c < 0 && AClkDiv == tgt) div_c = c;
      if (done_c < 0 && ADone != '0) begin done_c = c; err_at = AErr; end
      @(posedge AClkH); #2;
    end
    AEdgeSync = 1'b0; AClkHEn = 1'b1; AReq = '0;
  endtask

  initial begin
    int   d, dv, lo;
    logic er;
    int   rr_exp[5] = '{1, 2, 3, 0, 1};
    logic [N-1:0] req_q;

    do_reset();
    @(negedge AClkH);
    chk("rst_clkdiv", 32'(AClkDiv), 32'h170);
    chk("rst_gate_n", 32'(AGateN), 32'd1);
    chk("rst_grant", 32'(AGrant), 32'd0);
    chk("rst_busy", 32'(ABusy), 32'd0);
    repeat (99) @(negedge AClkH);
    chk("idle_clkdiv", 32'(AClkDiv), 32'h170);
    chk("idle_gate_n", 32'(AGateN), 32'd1);

    // Round-robin with all four held
    do_reset();
    done_log.delete();
    AReqDiv = {12'h404, 12'h303, 12'h202, 12'h101};
    AEdgeSync = 1'b1; AReq = '1;
    for (int c = 0; c < 500 && done_log.size() < 5; c++) @(posedge AClkH);
    #2 AReq = '0; AEdgeSync = 1'b0;
    chk("rr_count", 32'(done_log.size()), 32'd5);
    if (done_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(done_log[i]), 32'(rr_exp[i]));

    // Edge 5 cycles after GATE entry
    do_reset();
    AReqDiv[12 +: 12] = 12'h2A5; AReq = 4'b0010;
    run_seq(6, -1, 0, 200, 12'h2A5, d, dv, lo, er);
    chk("edge_done_cyc", 32'(d), 32'd24);
    chk("edge_div_cyc", 32'(dv), 32'd8);
    chk("edge_gate_low", 32'(lo), 32'd23);
    chk("edge_err", 32'(er), 32'd0);

    // Same value: no gating
    do_reset();
    AReqDiv[11:0] = 12'h170; AReq = 4'b0001;
    run_seq(-1, -1, 0, 50, 12'h170, d, dv, lo, er);
    chk("same_done_cyc", 32'(d), 32'd1);
    chk("same_gate_low", 32'(lo), 32'd0);
    chk("same_err", 32'(er), 32'd0);

    // Forced load by timeout
    do_reset();
    AReqDiv[11:0] = 12'h3C3; AReq = 4'b0001;
    run_seq(-1, -1, 0, 4300, 12'h3C3, d, dv, lo, er);
    chk("tmo_done_cyc", 32'(d), 32'd4114);
    chk("tmo_div_cyc", 32'(dv), 32'd4098);
    chk("tmo_gate_low", 32'(lo), 32'd4113);
    chk("tmo_err", 32'(er), 32'd1);

    // Enable low for 10 cycles mid-SETTLE
    do_reset();
    AReqDiv[12 +: 12] = 12'h055; AReq = 4'b0010;
    run_seq(6, 12, 10, 200, 12'h055, d, dv, lo, er);
    chk("en_done_cyc", 32'(d), 32'd34);
    chk("en_div_cyc", 32'(dv), 32'd8);
    chk("en_gate_low", 32'(lo), 32'd33);

    // Reset in the middle of GATE
    do_reset();
    AReqDiv[11:0] = 12'h3C3; AReq = 4'b0001;
    repeat (4) @(posedge AClkH);
    @(negedge AClkH);
    chk("mid_gate_low", 32'(AGateN), 32'd0);
    @(posedge AClkH);
    #2 AResetHN = 1'b0; AReq = '0;
    #1;
    chk("mid_rst_gate_n", 32'(AGateN), 32'd1);
    chk("mid_rst_clkdiv", 32'(AClkDiv), 32'h170);
    chk("mid_rst_grant", 32'(AGrant), 32'd0);
    repeat (2) @(posedge AClkH);
    #2 AResetHN = 1'b1;
    d = 0;
    repeat (30) begin
      @(negedge AClkH);
      if (ADone != '0) d++;
    end
    chk("mid_rst_no_done", 32'(d), 32'd0);

    // Randomized traffic against the model
    do_reset();
    req_q = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge AClkH); #2;
      for (int i = 0; i < N; i++) begin
        if (last_done[i] && $urandom_range(0, 3) != 0) req_q[i] = 1'b0;
        else if (!req_q[i] && $urandom_range(0, 5) == 0) begin
          req_q[i] = 1'b1;
          case ($urandom_range(0, 3))
            0: AReqDiv[i*12 +: 12] = 12'h170;
            1: AReqDiv[i*12 +: 12] = 12'h2A5;
            2: AReqDiv[i*12 +: 12] = 12'h000;
            default: AReqDiv[i*12 +: 12] = 12'($urandom);
          endcase
        end else if (req_q[i] && $urandom_range(0, 40) == 0) req_q[i] = 1'b0;
        if ($urandom_range(0, 15) == 0) AReqDiv[i*12 +: 12] = 12'($urandom);
      end
      AReq      = req_q;
      AEdgeSync = ($urandom_range(0, 7) == 0);
      AClkHEn   = ($urandom_range(0, 7) != 0);
    end
    @(posedge AClkH); #2;
    AReq = '0; AEdgeSync = 1'b1; AClkHEn = 1'b1;
    repeat (60) @(posedge AClkH);
    #2 AEdgeSync = 1'b0;
    @(negedge AClkH);
    chk("drain_busy", 32'(ABusy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
